// File: rtl/cla_nibble_sched.sv
// cla_nibble_sched: two-requester front end sharing one 4-bit carry-lookahead
// slice. An accepted operation is added one nibble per cycle, least-significant
// first, with the slice carry fed back through a register. The result is held
// until the consumer takes it.
module cla_nibble_sched #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,

  input  logic                 in0_valid,
  output logic                 in0_ready,
  input  logic [4*NIBBLES-1:0] in0_a,
  input  logic [4*NIBBLES-1:0] in0_b,
  input  logic                 in0_cin,

  input  logic                 in1_valid,
  output logic                 in1_ready,
  input  logic [4*NIBBLES-1:0] in1_a,
  input  logic [4*NIBBLES-1:0] in1_b,
  input  logic                 in1_cin,

  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] out_sum,
  output logic                 out_cout,
  output logic                 out_id,
  output logic                 busy
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // 4-bit carry-lookahead slice: every internal carry is formed directly from
  // generate/propagate terms and the slice carry-in, no ripple between bits.
  function automatic logic [4:0] cla4(input logic [3:0] a,
                                      input logic [3:0] b,
                                      input logic       c0);
    logic [3:0] g;
    logic [3:0] p;
    logic       c1, c2, c3, c4;
    g  = a & b;
    p  = a ^ b;
    c1 = g[0] | (p[0] & c0);
    c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c0);
    c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c0);
    return {c4, p ^ {c3, c2, c1, c0}};
  endfunction

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q,   idx_d;
  logic             carry_q, carry_d;
  logic [W-1:0]     sum_q,   sum_d;
  logic             cout_q,  cout_d;
  logic             id_q,    id_d;
  logic             last_q,  last_d;
  logic [W-1:0]     a_q,     a_d;
  logic [W-1:0]     b_q,     b_d;

  logic             grant_id;
  logic             accept;
  logic [3:0]       nib_a;
  logic [3:0]       nib_b;
  logic [3:0]       slice_sum;
  logic             slice_cout;

  // Round-robin pick: a lone requester always wins, a tie goes to the one
  // that was not granted last. Acceptance is only possible in IDLE.
  always_comb begin
    if (in0_valid && in1_valid) begin
      grant_id = !last_q;
    end else begin
      grant_id = in1_valid;
    end
    accept = (state_q == S_IDLE) && (in0_valid || in1_valid);
  end

  assign in0_ready = accept && !grant_id;
  assign in1_ready = accept &&  grant_id;
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_id    = id_q;

  // Route the current nibble of the captured operands to the shared slice.
  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int n = 0; n < NIBBLES; n++) begin
      if (idx_q == IDX_W'(n)) begin
        nib_a = a_q[4*n +: 4];
        nib_b = b_q[4*n +: 4];
      end
    end
  end

  assign {slice_cout, slice_sum} = cla4(nib_a, nib_b, carry_q);

  // Next-state and datapath update for IDLE -> RUN -> DONE sequencing.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    id_d    = id_q;
    last_d  = last_q;
    a_d     = a_q;
    b_d     = b_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          a_d     = grant_id ? in1_a   : in0_a;
          b_d     = grant_id ? in1_b   : in0_b;
          carry_d = grant_id ? in1_cin : in0_cin;
          id_d    = grant_id;
          last_d  = grant_id;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        for (int n = 0; n < NIBBLES; n++) begin
          if (idx_q == IDX_W'(n)) begin
            sum_d[4*n +: 4] = slice_sum;
          end
        end
        carry_d = slice_cout;
        if (idx_q == LAST_IDX) begin
          cout_d  = slice_cout;
          idx_d   = '0;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      S_DONE: begin
        // Result registers are left untouched so they stay stable until taken.
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and result state; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      id_q    <= id_d;
      last_q  <= last_d;
    end
  end

  // Captured operands; only meaningful while an operation is in flight.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

endmodule

// File: tb/tb_cla_nibble_sched.sv
// Bench for cla_nibble_sched (NIBBLES=4): directed scenarios plus randomized
// transactions checked against an arithmetic reference model.
module tb_cla_nibble_sched;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic         clk;
  logic         rst_n;
  logic         in0_valid, in0_ready, in0_cin;
  logic [W-1:0] in0_a, in0_b;
  logic         in1_valid, in1_ready, in1_cin;
  logic [W-1:0] in1_a, in1_b;
  logic         out_valid, out_ready, out_cout, out_id, busy;
  logic [W-1:0] out_sum;

  int errors = 0;
  int checks = 0;
  logic last_grant;  // model: requester granted most recently

  cla_nibble_sched #(.NIBBLES(NIB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in0_valid (in0_valid),
    .in0_ready (in0_ready),
    .in0_a     (in0_a),
    .in0_b     (in0_b),
    .in0_cin   (in0_cin),
    .in1_valid (in1_valid),
    .in1_ready (in1_ready),
    .in1_a     (in1_a),
    .in1_b     (in1_b),
    .in1_cin   (in1_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_id    (out_id),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic scramble();
    in0_valid = 1'($urandom);
    in1_valid = 1'($urandom);
    in0_a     = W'($urandom);
    in0_b     = W'($urandom);
    in1_a     = W'($urandom);
    in1_b     = W'($urandom);
    in0_cin   = 1'($urandom);
    in1_cin   = 1'($urandom);
  endtask

  // One full transaction: present requests, check the grant, disturb inputs
  // while in flight, hold the result for 'hold' cycles, then take it.
  task automatic run_txn(input logic v0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                         input logic c0, input logic v1, input logic [W-1:0] a1,
                         input logic [W-1:0] b1, input logic c1, input int hold);
    logic         gid;
    logic [W:0]   expv;
    logic [W-1:0] ea, eb;
    logic         ec;
    @(negedge clk);
    in0_valid = v0; in0_a = a0; in0_b = b0; in0_cin = c0;
    in1_valid = v1; in1_a = a1; in1_b = b1; in1_cin = c1;
    out_ready = 1'b0;
    gid  = (v0 && v1) ? !last_grant : v1;
    ea   = gid ? a1 : a0;
    eb   = gid ? b1 : b0;
    ec   = gid ? c1 : c0;
    expv = {1'b0, ea} + {1'b0, eb} + {{W{1'b0}}, ec};
    #1;
    chk("acc_in0_ready", in0_ready, !gid);
    chk("acc_in1_ready", in1_ready, gid);
    chk("acc_busy", busy, 0);
    last_grant = gid;
    @(posedge clk);
    for (int c = 1; c <= NIB; c++) begin
      @(negedge clk);
      scramble();
      #1;
      chk("run_out_valid", out_valid, 0);
      chk("run_busy", busy, 1);
      chk("run_readies", {in0_ready, in1_ready}, 0);
    end
    for (int h = 0; h <= hold; h++) begin
      @(negedge clk);
      scramble();
      out_ready = (h == hold);
      #1;
      chk("done_out_valid", out_valid, 1);
      chk("done_sum", out_sum, expv[W-1:0]);
      chk("done_cout", out_cout, expv[W]);
      chk("done_id", out_id, gid);
      chk("done_busy", busy, 1);
      chk("done_readies", {in0_ready, in1_ready}, 0);
    end
    @(posedge clk);
    @(negedge clk);
    in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("idle_out_valid", out_valid, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    logic         gid;
    logic [W:0]   qv;
    logic         qi;
    logic [W:0]   expq[$];
    logic         idq[$];
    int           acc, res, last_cyc;

    rst_n = 1'b0; out_ready = 1'b0;
    in0_valid = 1'b0; in0_a = '0; in0_b = '0; in0_cin = 1'b0;
    in1_valid = 1'b0; in1_a = '0; in1_b = '0; in1_cin = 1'b0;
    last_grant = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_cout", out_cout, 0);
    chk("rst_out_id", out_id, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Both requesters held valid: alternating grants six cycles apart.
    acc = 0; res = 0; last_cyc = -1;
    for (int cyc = 0; cyc < 80 && res < 4; cyc++) begin
      @(negedge clk);
      in0_a = W'($urandom); in0_b = W'($urandom); in0_cin = 1'($urandom);
      in1_a = W'($urandom); in1_b = W'($urandom); in1_cin = 1'($urandom);
      in0_valid = (acc < 4); in1_valid = (acc < 4); out_ready = 1'b1;
      #1;
      if (out_valid) begin
        chk("rr_result_pending", expq.size() > 0, 1);
        if (expq.size() > 0) begin
          qv = expq.pop_front();
          qi = idq.pop_front();
          chk("rr_sum", out_sum, qv[W-1:0]);
          chk("rr_cout", out_cout, qv[W]);
          chk("rr_id", out_id, qi);
        end
        res++;
      end
      if (in0_ready || in1_ready) begin
        gid = in1_ready;
        chk("rr_onehot", in0_ready && in1_ready, 0);
        chk("rr_grant", gid, !last_grant);
        if (last_cyc >= 0) chk("rr_spacing", cyc - last_cyc, 6);
        qv = gid ? ({1'b0, in1_a} + {1'b0, in1_b} + {{W{1'b0}}, in1_cin})
                 : ({1'b0, in0_a} + {1'b0, in0_b} + {{W{1'b0}}, in0_cin});
        expq.push_back(qv);
        idq.push_back(gid);
        last_grant = gid;
        last_cyc = cyc;
        acc++;
      end
    end
    chk("rr_results", res, 4);
    @(negedge clk);
    in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b0;

    // Directed sums, including a carry through every nibble and a held result.
    run_txn(1'b1, 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 0);
    run_txn(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'hFFFF, 16'h0000, 1'b1, 0);
    run_txn(1'b1, 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 3);
    run_txn(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0F0F, 16'h1111, 1'b0, 1);

    // Reset while the third nibble is being added.
    @(negedge clk);
    in0_valid = 1'b1; in0_a = 16'h7777; in0_b = 16'h1999; in0_cin = 1'b1;
    #1;
    chk("abort_accept", in0_ready, 1);
    @(posedge clk);
    repeat (3) @(negedge clk);
    in0_valid = 1'b0;
    rst_n = 1'b0;
    last_grant = 1'b1;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_out_sum", out_sum, 0);
    chk("abort_out_cout", out_cout, 0);
    chk("abort_out_id", out_id, 0);
    chk("abort_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      #1;
      chk("abort_no_result", out_valid, 0);
    end
    run_txn(1'b1, 16'h2468, 16'h1357, 1'b1, 1'b1, 16'hAAAA, 16'h5555, 1'b1, 0);

    // Randomized traffic.
    for (int t = 0; t < 16; t++) begin
      logic rv0, rv1;
      rv0 = 1'($urandom);
      rv1 = 1'($urandom);
      if (!rv0 && !rv1) rv0 = 1'b1;
      run_txn(rv0, W'($urandom), W'($urandom), 1'($urandom),
              rv1, W'($urandom), W'($urandom), 1'($urandom),
              int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
